tetris_pixel_source: RTL and testbench
======================================

Name: tetris_pixel_source

Overview:
- Pixel-supply end of the display interface. Consumes the display controller's `v_sync` and `pixel_en` and returns `rgb_8`.
- Reconstructs the current pixel column and row, and maps pixels inside the 10x20 Tetris playfield to board-memory reads.
- Drives `rgb_8` through an 8-entry palette. Pixels outside the playfield get border or background colour.
- Raises a one-cycle `frame_done` strobe at end of frame, so game logic updates the board during vertical blanking.

Parameters:
- CLKS_PER_PIXEL, 20, clocks per displayed pixel while `pixel_en` is high; must be 4 or more.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- CELL_PX, 16, pixel width and height of one board cell.
- FIELD_X0, 240, first pixel column of the playfield.
- FIELD_Y0, 80, first line of the playfield.
- BORDER_PX, 4, border thickness around the playfield.

Ports:
- clk  in  1  system clock, same clock as the display controller.
- rst  in  1  asynchronous, active-low reset.
- v_sync  in  1  vertical sync from the display controller.
- pixel_en  in  1  active-video window from the display controller.
- board_addr  out  8  board RAM read address, row*10+col, range 0..199.
- board_data  in  3  cell colour index; valid 1 clk after board_addr; 0 means empty.
- rgb_8  out  8  pixel colour {R[2:0],G[2:0],B[1:0]}.
- pix_x  out  10  current pixel column.
- pix_y  out  9  current active line.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset while rst=0 (async assert, sync release): pix_x=0, pix_y=0, sub-pixel counter=0, rgb_8=0, board_addr=0, frame_done=0, all edge-detect registers=0.
- Edge detection: `pixel_en` and `v_sync` are each registered once, and edges are detected against that registered copy.
- v_sync rising edge (frame start):
  - pix_y cleared to 0.
  - first_line flag set.
- pixel_en rising edge (line start):
  - pix_x=0 and sub-pixel counter=0.
  - If first_line is clear, pix_y increments, saturating at V_ACTIVE-1.
  - first_line is then cleared, so the first active line of a frame is y=0.
- During pixel_en=1:
  - Sub-pixel counter counts 0..CLKS_PER_PIXEL-1.
  - At the terminal count, the counter wraps and pix_x increments, saturating at H_ACTIVE-1 (no wrap to 0).
- v_sync falling edge: frame_done=1 for exactly one clk. No other event produces it.
- Coincident v_sync rising and pixel_en rising in the same clk: frame start takes effect first, so that line is y=0.
- Region classification, combinational on pix_x/pix_y:
  - FIELD: X0 <= x < X0+10*CELL_PX and Y0 <= y < Y0+20*CELL_PX.
  - BORDER: within BORDER_PX outside the FIELD rectangle.
  - Otherwise BACKGROUND.
  - col=(x-X0)/CELL_PX and row=(y-Y0)/CELL_PX, computed by shifts since CELL_PX is a power of two.
- Pipeline:
  - Stage 1 (registered): board_addr = row*10+col, computed as (row<<3)+(row<<1)+col. The region class and a grid flag are registered alongside it. The grid flag is set when the x or y offset inside the cell is 0.
  - Stage 2 (registered): rgb_8 is driven as follows.
    - FIELD with board_data≠0: palette[board_data], dimmed by halving each channel when the grid flag is set.
    - FIELD with board_data=0: palette[0].
    - BORDER: 8'b101_101_10.
    - BACKGROUND: 8'h00.
- Latency: rgb_8 is valid from clock 2 after a pix_x change and holds to the end of that pixel. CLKS_PER_PIXEL>=4 guarantees at least 2 valid clks per pixel.
- When pixel_en=0: rgb_8 is forced to 0 on the next clk, and board_addr holds its last value.
- Palette (index → rgb_8):
  - 0=00, 1=1F (cyan), 2=03 (blue), 3=F4 (orange), 4=FC (yellow), 5=1C (green), 6=A3 (purple), 7=E0 (red).
- Reset mid-line: all outputs return to reset values immediately. After release, the block stays idle until the next pixel_en rising edge; pix_y stays at 0 until the next v_sync rising edge.

Decomposition:
- Package tetris_vga_pkg holds:
  - board dimensions (10, 20);
  - palette constant array and border colour;
  - region enum {BACKGROUND, BORDER, FIELD};
  - rgb_8 bit-field positions.
- Sub-module vga_pixel_counter owns the edge detectors, sub-pixel counter, pix_x/pix_y and frame_done.
- The top level handles region mapping, the address pipeline and the palette.

Test Plan:
- Reset: hold rst=0 for 5 clk with random inputs -> rgb_8=0, pix_x=0, pix_y=0, frame_done=0 throughout.
- Line timing: v_sync 0→1, then pixel_en high for 12800 clk -> pix_x steps every 20 clk, reaches 639, and holds 639 after that.
- Board fetch: board RAM cell (row 0, col 0)=3; drive pixel (240,80) -> board_addr=0 and, 2 clk later, rgb_8=dimmed orange (grid). Pixel (241,81) -> rgb_8=F4.
- Last cell: cell (19,9)=7; pixel (399,399) -> board_addr=199 and rgb_8=E0. Pixel (400,80) -> border colour B6. Pixel (0,0) -> 00.
- Frame sequencing: 3 frames of 480 pixel_en pulses each -> pix_y runs 0..479 per frame, saturates on extra lines, and frame_done is exactly one 1-clk pulse per v_sync fall.
- Reset mid-line: assert rst at pix_x=300 -> immediate zeros. After release, the next pixel_en rise restarts at pix_x=0.

Source files
------------

// File: rtl/tetris_vga_pkg.sv
// Shared constants for the Tetris pixel source: board geometry, palette,
// region classes and rgb_8 field layout.
package tetris_vga_pkg;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;

  localparam int ADDR_W = 8;
  localparam int CIDX_W = 3;
  localparam int RGB_W  = 8;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  // rgb_8 = {R[2:0], G[2:0], B[1:0]}
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  localparam logic [RGB_W-1:0] PALETTE [8] = '{
    8'h00, 8'h1F, 8'h03, 8'hF4, 8'hFC, 8'h1C, 8'hA3, 8'hE0
  };

  localparam logic [RGB_W-1:0] BORDER_RGB = 8'b101_101_10;

  typedef enum logic [1:0] {
    BACKGROUND,
    BORDER,
    FIELD
  } region_t;

  // Halve every channel by dropping its LSB.
  function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] c);
    return {1'b0, c[R_MSB:R_LSB+1],
            1'b0, c[G_MSB:G_LSB+1],
            1'b0, c[B_MSB:B_LSB+1]};
  endfunction

endpackage

// File: rtl/tetris_pixel_source_if.sv
// Display-side and board-memory signals of the Tetris pixel source.
interface tetris_pixel_source_if;
  import tetris_vga_pkg::*;

  logic              v_sync;
  logic              pixel_en;
  logic [ADDR_W-1:0] board_addr;
  logic [CIDX_W-1:0] board_data;
  logic [RGB_W-1:0]  rgb_8;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic              frame_done;

  modport master (
    input  v_sync, pixel_en, board_data,
    output board_addr, rgb_8, pix_x, pix_y, frame_done
  );

  modport slave (
    output v_sync, pixel_en, board_data,
    input  board_addr, rgb_8, pix_x, pix_y, frame_done
  );

endinterface

// File: rtl/vga_pixel_counter.sv
// Rebuilds pixel column/row from v_sync and pixel_en edges and flags
// end of frame on the v_sync falling edge.
module vga_pixel_counter
  import tetris_vga_pkg::*;
#(
  parameter int CLKS_PER_PIXEL = 20,
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           v_sync,
  input  logic           pixel_en,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           frame_done
);

  localparam int SUB_W = $clog2(CLKS_PER_PIXEL);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLKS_PER_PIXEL - 1);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_ACTIVE - 1);

  logic             v_sync_q;
  logic             pixel_en_q;
  logic             first_line;
  logic             frame_valid;
  logic [SUB_W-1:0] sub_cnt;

  logic vs_rise;
  logic vs_fall;
  logic pe_rise;

  assign vs_rise = v_sync & ~v_sync_q;
  assign vs_fall = ~v_sync & v_sync_q;
  assign pe_rise = pixel_en & ~pixel_en_q;

  // frame_valid keeps pix_y pinned at 0 after reset until a real frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_sync_q    <= 1'b0;
      pixel_en_q  <= 1'b0;
      first_line  <= 1'b0;
      frame_valid <= 1'b0;
      sub_cnt     <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_done  <= 1'b0;
    end else begin
      v_sync_q   <= v_sync;
      pixel_en_q <= pixel_en;
      frame_done <= vs_fall;

      if (vs_rise) begin
        pix_y       <= '0;
        first_line  <= 1'b1;
        frame_valid <= 1'b1;
      end

      if (pe_rise) begin
        pix_x      <= '0;
        sub_cnt    <= '0;
        first_line <= 1'b0;
        if (vs_rise) begin
          pix_y <= '0;
        end else if (frame_valid && !first_line && (pix_y != Y_LAST)) begin
          pix_y <= pix_y + 1'b1;
        end
      end else if (pixel_en) begin
        if (sub_cnt == SUB_LAST) begin
          sub_cnt <= '0;
          if (pix_x != X_LAST) begin
            pix_x <= pix_x + 1'b1;
          end
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tetris_pixel_source.sv
// Pixel source for the Tetris display: maps pixels onto the 10x20 board,
// fetches cell colours and drives rgb_8 through the palette.
module tetris_pixel_source
  import tetris_vga_pkg::*;
#(
  parameter int CLKS_PER_PIXEL = 20,
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int CELL_PX        = 16,
  parameter int FIELD_X0       = 240,
  parameter int FIELD_Y0       = 80,
  parameter int BORDER_PX      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  tetris_pixel_source_if.master bus
);

  localparam int CELL_SHIFT = $clog2(CELL_PX);
  localparam int FIELD_W    = BOARD_COLS * CELL_PX;
  localparam int FIELD_H    = BOARD_ROWS * CELL_PX;

  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           frame_done;

  vga_pixel_counter #(
    .CLKS_PER_PIXEL (CLKS_PER_PIXEL),
    .H_ACTIVE       (H_ACTIVE),
    .V_ACTIVE       (V_ACTIVE)
  ) u_pixel_counter (
    .clk        (clk),
    .rst        (rst),
    .v_sync     (bus.v_sync),
    .pixel_en   (bus.pixel_en),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_done (frame_done)
  );

  assign bus.pix_x      = pix_x;
  assign bus.pix_y      = pix_y;
  assign bus.frame_done = frame_done;

  int          dx;
  int          dy;
  logic        in_field;
  logic        in_frame;
  logic        grid;
  logic [3:0]  col;
  logic [4:0]  row;
  logic [ADDR_W-1:0] addr_next;
  region_t     region;

  // Offsets are signed so pixels left of / above the field compare correctly.
  always_comb begin
    dx        = int'(pix_x) - FIELD_X0;
    dy        = int'(pix_y) - FIELD_Y0;
    in_field  = (dx >= 0) && (dx < FIELD_W) && (dy >= 0) && (dy < FIELD_H);
    in_frame  = (dx >= -BORDER_PX) && (dx < FIELD_W + BORDER_PX) &&
                (dy >= -BORDER_PX) && (dy < FIELD_H + BORDER_PX);
    region    = BACKGROUND;
    if (in_field) begin
      region = FIELD;
    end else if (in_frame) begin
      region = BORDER;
    end
    col       = 4'(dx >>> CELL_SHIFT);
    row       = 5'(dy >>> CELL_SHIFT);
    grid      = ((dx & (CELL_PX - 1)) == 0) || ((dy & (CELL_PX - 1)) == 0);
    addr_next = ({3'b000, row} << 3) + ({3'b000, row} << 1) + {4'b0000, col};
  end

  logic [ADDR_W-1:0] board_addr_q;
  region_t           region_q;
  logic              grid_q;

  // Address only moves inside the field so it never leaves 0..199.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board_addr_q <= '0;
      region_q     <= BACKGROUND;
      grid_q       <= 1'b0;
    end else if (bus.pixel_en) begin
      region_q <= region;
      grid_q   <= grid;
      if (region == FIELD) begin
        board_addr_q <= addr_next;
      end
    end
  end

  assign bus.board_addr = board_addr_q;

  logic [RGB_W-1:0] colour;

  always_comb begin
    colour = 8'h00;
    case (region_q)
      FIELD: begin
        if (bus.board_data != '0) begin
          colour = grid_q ? dim_rgb(PALETTE[bus.board_data])
                          : PALETTE[bus.board_data];
        end else begin
          colour = PALETTE[0];
        end
      end
      BORDER:  colour = BORDER_RGB;
      default: colour = 8'h00;
    endcase
  end

  logic [RGB_W-1:0] rgb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= bus.pixel_en ? colour : 8'h00;
    end
  end

  assign bus.rgb_8 = rgb_q;

endmodule

// File: tb/tb_tetris_pixel_source.sv
// Directed bench for tetris_pixel_source: reset, line timing, pixel/colour
// vectors, frame sequencing and mid-line reset.
module tb_tetris_pixel_source;

  typedef struct {
    int         x;
    int         y;
    int         addr;   // -1: outside field, address not checked
    logic [7:0] rgb;
  } vec_t;

  logic clk;
  logic rst;

  tetris_pixel_source_if bus ();

  tetris_pixel_source dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [2:0] ram [256];
  assign bus.board_data = ram[bus.board_addr];

  int   checks    = 0;
  int   errors    = 0;
  int   vs_falls  = 0;
  int   fd_pulses = 0;
  int   fd_wide   = 0;
  logic fd_prev   = 1'b0;
  vec_t vecs [11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) begin
      fd_pulses++;
      if (fd_prev) fd_wide++;
    end
    fd_prev = bus.frame_done;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic vsync_pulse();
    bus.v_sync = 1'b1;
    repeat (3) @(negedge clk);
    bus.v_sync = 1'b0;
    vs_falls++;
    repeat (3) @(negedge clk);
  endtask

  task automatic line_pulse();
    bus.pixel_en = 1'b1;
    @(negedge clk);
    bus.pixel_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_x(input int x);
    int n = 0;
    while (int'(bus.pix_x) != x && n < x * 20 + 60) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach_x_%0d", x), int'(bus.pix_x), x);
  endtask

  initial begin
    rst          = 1'b0;
    bus.v_sync   = 1'b0;
    bus.pixel_en = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 3'd0;
    ram[0]   = 3'd3;
    ram[1]   = 3'd4;
    ram[12]  = 3'd1;
    ram[199] = 3'd7;

    vecs[0]  = '{240,  80,   0, 8'h68};
    vecs[1]  = '{241,  81,   0, 8'hF4};
    vecs[2]  = '{399, 399, 199, 8'hE0};
    vecs[3]  = '{400,  80,  -1, 8'hB6};
    vecs[4]  = '{  0,   0,  -1, 8'h00};
    vecs[5]  = '{ 10, 300,  -1, 8'h00};
    vecs[6]  = '{272,  96,  12, 8'h0D};
    vecs[7]  = '{283, 110,  12, 8'h1F};
    vecs[8]  = '{300, 200,  73, 8'h00};
    vecs[9]  = '{236,  76,  -1, 8'hB6};
    vecs[10] = '{256,  80,   1, 8'h6C};

    // reset with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("reset_rgb_%0d", i), int'(bus.rgb_8), 0);
      check($sformatf("reset_x_%0d", i), int'(bus.pix_x), 0);
      check($sformatf("reset_y_%0d", i), int'(bus.pix_y), 0);
      check($sformatf("reset_fd_%0d", i), int'(bus.frame_done), 0);
      check($sformatf("reset_addr_%0d", i), int'(bus.board_addr), 0);
      bus.v_sync   = 1'($urandom_range(0, 1));
      bus.pixel_en = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.v_sync   = 1'b0;
    bus.pixel_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // one long line: pix_x steps every 20 clk and saturates at 639
    vsync_pulse();
    bus.pixel_en = 1'b1;
    for (int k = 0; k < 13000; k++) begin
      @(negedge clk);
      if (k % 20 == 0 || k % 20 == 19)
        check($sformatf("line_x_k%0d", k), int'(bus.pix_x), (k / 20 > 639) ? 639 : k / 20);
    end
    check("line_y", int'(bus.pix_y), 0);
    bus.pixel_en = 1'b0;
    @(negedge clk);

    // pixel vectors
    foreach (vecs[v]) begin
      vsync_pulse();
      for (int l = 0; l < vecs[v].y; l++) line_pulse();
      bus.pixel_en = 1'b1;
      @(negedge clk);
      wait_x(vecs[v].x);
      check($sformatf("vec%0d_y", v), int'(bus.pix_y), vecs[v].y);
      @(negedge clk);
      if (vecs[v].addr >= 0)
        check($sformatf("vec%0d_addr", v), int'(bus.board_addr), vecs[v].addr);
      @(negedge clk);
      check($sformatf("vec%0d_rgb", v), int'(bus.rgb_8), int'(vecs[v].rgb));
      bus.pixel_en = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_rgb_off", v), int'(bus.rgb_8), 0);
      if (vecs[v].addr >= 0)
        check($sformatf("vec%0d_addr_hold", v), int'(bus.board_addr), vecs[v].addr);
    end

    // three frames with extra lines past V_ACTIVE
    for (int f = 0; f < 3; f++) begin
      vsync_pulse();
      for (int l = 0; l < 482; l++) begin
        bus.pixel_en = 1'b1;
        @(negedge clk);
        check($sformatf("frame%0d_y%0d", f, l), int'(bus.pix_y), (l > 479) ? 479 : l);
        bus.pixel_en = 1'b0;
        @(negedge clk);
      end
      check($sformatf("frame%0d_done_count", f), fd_pulses, vs_falls);
    end

    // v_sync and pixel_en rising together
    bus.v_sync   = 1'b1;
    bus.pixel_en = 1'b1;
    @(negedge clk);
    check("coincident_y0", int'(bus.pix_y), 0);
    bus.pixel_en = 1'b0;
    @(negedge clk);
    bus.pixel_en = 1'b1;
    @(negedge clk);
    check("coincident_y1", int'(bus.pix_y), 1);
    bus.pixel_en = 1'b0;
    bus.v_sync   = 1'b0;
    vs_falls++;
    repeat (3) @(negedge clk);

    // reset in the middle of a line
    vsync_pulse();
    line_pulse();
    line_pulse();
    bus.pixel_en = 1'b1;
    @(negedge clk);
    wait_x(300);
    #2 rst = 1'b0;
    #1;
    check("midrst_x", int'(bus.pix_x), 0);
    check("midrst_y", int'(bus.pix_y), 0);
    check("midrst_rgb", int'(bus.rgb_8), 0);
    check("midrst_addr", int'(bus.board_addr), 0);
    check("midrst_fd", int'(bus.frame_done), 0);
    @(negedge clk);
    bus.pixel_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_x", int'(bus.pix_x), 0);
    check("post_rst_idle_rgb", int'(bus.rgb_8), 0);
    bus.pixel_en = 1'b1;
    @(negedge clk);
    check("post_rst_x0", int'(bus.pix_x), 0);
    repeat (20) @(negedge clk);
    check("post_rst_x1", int'(bus.pix_x), 1);
    check("post_rst_y0", int'(bus.pix_y), 0);
    bus.pixel_en = 1'b0;
    @(negedge clk);
    line_pulse();
    check("post_rst_y_hold", int'(bus.pix_y), 0);
    vsync_pulse();
    line_pulse();
    line_pulse();
    check("post_rst_new_frame_y", int'(bus.pix_y), 1);

    repeat (4) @(negedge clk);
    check("frame_done_total", fd_pulses, vs_falls);
    check("frame_done_width", fd_wide, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
